// File: rtl/adma_as_chn_sched.sv
// adma_as_chn_sched: weighted round-robin scheduler forwarding per-channel DMA requests (chn_tx_*) into a one-entry output register (tx_*)
module adma_as_chn_sched #(
  parameter int DMA_CHN_NUM = 4,
  parameter int DMA_CHN_ARB_W = 3,
  parameter int DMA_LENGTH_W = 16,
  parameter int SRC_ADDR_W = 32,
  parameter int DST_ADDR_W = 32,
  localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0]     chn_tx_src_addr,
  input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]     chn_tx_dst_addr,
  input  logic [DMA_CHN_NUM*DMA_LENGTH_W-1:0]   chn_tx_len,
  input  logic [DMA_CHN_NUM-1:0]                chn_tx_vld,
  output logic [DMA_CHN_NUM-1:0]                chn_tx_rdy,
  input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]  chn_arb_weight,
  output logic [SRC_ADDR_W-1:0]                 tx_src_addr,
  output logic [DST_ADDR_W-1:0]                 tx_dst_addr,
  output logic [DMA_LENGTH_W-1:0]               tx_len,
  output logic [DMA_CHN_NUM_W-1:0]              tx_chn_id,
  output logic                                  tx_vld,
  input  logic                                  tx_rdy,
  output logic                                  sched_busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [DMA_CHN_NUM_W-1:0] gnt, ptr, sel, idx, gnt_nxt;
  logic [DMA_CHN_ARB_W-1:0] crd;
  logic [DMA_CHN_NUM-1:0] elig;
  logic any, arm, out_free, xfer;
  for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_elig
    assign elig[i] = chn_tx_vld[i] & |chn_arb_weight[i*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
  end
  always_comb begin
    any = |elig;
    sel = '0;
    idx = '0;
    for (int k = DMA_CHN_NUM - 1; k >= 0; k--) begin
      idx = DMA_CHN_NUM_W'((int'(ptr) + k) % DMA_CHN_NUM);
      sel = elig[idx] ? idx : sel;
    end
  end
  assign gnt_nxt = DMA_CHN_NUM_W'((int'(gnt) + 1) % DMA_CHN_NUM);
  assign out_free = ~tx_vld | tx_rdy;
  assign xfer = (state == GRANT) & chn_tx_vld[gnt] & out_free;
  assign chn_tx_rdy = (state == GRANT && out_free) ? DMA_CHN_NUM'(1) << gnt : '0;
  assign sched_busy = (state == GRANT) | tx_vld;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      crd <= '0;
      ptr <= '0;
      arm <= 1'b0;
      tx_vld <= 1'b0;
      tx_chn_id <= '0;
      tx_src_addr <= '0;
      tx_dst_addr <= '0;
      tx_len <= '0;
    end else begin
      arm <= 1'b1;
      if (xfer) begin
        tx_src_addr <= chn_tx_src_addr[gnt*SRC_ADDR_W +: SRC_ADDR_W];
        tx_dst_addr <= chn_tx_dst_addr[gnt*DST_ADDR_W +: DST_ADDR_W];
        tx_len <= chn_tx_len[gnt*DMA_LENGTH_W +: DMA_LENGTH_W];
        tx_chn_id <= gnt;
        tx_vld <= 1'b1;
      end else if (tx_rdy) begin
        tx_vld <= 1'b0;
      end
      if (state == IDLE) begin
        if (any && arm) begin
          state <= GRANT;
          gnt <= sel;
          crd <= chn_arb_weight[sel*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
        end
      end else if (!chn_tx_vld[gnt]) begin
        state <= IDLE;
        ptr <= gnt_nxt;
      end else if (out_free) begin
        crd <= crd - 1'b1;
        if (crd == DMA_CHN_ARB_W'(1)) begin
          state <= IDLE;
          ptr <= gnt_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_adma_as_chn_sched.sv
// tb_adma_as_chn_sched: table-driven directed check of the weighted round-robin channel scheduler
module tb_adma_as_chn_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [127:0] chn_tx_src_addr, chn_tx_dst_addr;
  logic [63:0] chn_tx_len;
  logic [3:0] chn_tx_vld, chn_tx_rdy;
  logic [11:0] chn_arb_weight;
  logic [31:0] tx_src_addr, tx_dst_addr;
  logic [15:0] tx_len;
  logic [1:0] tx_chn_id;
  logic tx_vld, tx_rdy, sched_busy;
  int checks = 0;
  int failures = 0;
  adma_as_chn_sched dut (
    .clk(clk), .rst_n(rst_n),
    .chn_tx_src_addr(chn_tx_src_addr), .chn_tx_dst_addr(chn_tx_dst_addr),
    .chn_tx_len(chn_tx_len), .chn_tx_vld(chn_tx_vld), .chn_tx_rdy(chn_tx_rdy),
    .chn_arb_weight(chn_arb_weight),
    .tx_src_addr(tx_src_addr), .tx_dst_addr(tx_dst_addr), .tx_len(tx_len),
    .tx_chn_id(tx_chn_id), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .sched_busy(sched_busy)
  );
  typedef struct {
    bit rst;
    bit chk;
    bit zp;
    logic [3:0] vld;
    logic [11:0] w;
    bit trdy;
    logic [3:0] rdy;
    bit tv;
    logic [1:0] id;
    bit busy;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [31:0] src_of(int i);
    return 32'hA000_0000 + 32'(i) * 32'h1111;
  endfunction
  function automatic logic [31:0] dst_of(int i);
    return 32'hB000_0000 + 32'(i) * 32'h2222;
  endfunction
  function automatic logic [15:0] len_of(int i);
    return 16'h0100 + 16'(i) * 16'd3;
  endfunction
  function automatic logic [11:0] wt(int a, int b, int c, int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction
  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic r(bit rs, bit ck, bit zp, logic [3:0] v, logic [11:0] w, bit tr,
                   logic [3:0] rd, bit tv, logic [1:0] id, bit bz);
    tbl.push_back('{rs, ck, zp, v, w, tr, rd, tv, id, bz});
  endtask
  initial begin
    logic [11:0] w1, wb, wm, wp, wy;
    int cnt;
    w1 = wt(1, 1, 1, 1);
    wb = wt(1, 2, 3, 1);
    wm = wt(1, 0, 1, 1);
    wp = wt(3, 1, 1, 1);
    wy = wt(1, 1, 1, 4);
    for (int i = 0; i < 4; i++) begin
      chn_tx_src_addr[i*32 +: 32] = src_of(i);
      chn_tx_dst_addr[i*32 +: 32] = dst_of(i);
      chn_tx_len[i*16 +: 16] = len_of(i);
    end
    rst_n = 1'b0;
    chn_tx_vld = '0;
    chn_arb_weight = '0;
    tx_rdy = 1'b1;
    // single request on ch2, then ptr=3 check via ch1/ch3 contention
    r(0, 0, 0, 4'b0000, w1, 1, 4'b0000, 0, 0, 0);
    r(0, 1, 1, 4'b0000, w1, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0100, w1, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0100, w1, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b0100, w1, 1, 4'b0100, 0, 0, 1);
    r(1, 1, 0, 4'b0000, w1, 1, 4'b0000, 1, 2, 1);
    r(1, 1, 0, 4'b0000, w1, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1010, w1, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1010, w1, 1, 4'b1000, 0, 0, 1);
    r(1, 1, 0, 4'b1010, w1, 1, 4'b0000, 1, 3, 1);
    r(1, 1, 0, 4'b0010, w1, 1, 4'b0010, 0, 0, 1);
    r(1, 1, 0, 4'b0000, w1, 1, 4'b0000, 1, 1, 1);
    r(1, 1, 0, 4'b0000, w1, 1, 4'b0000, 0, 0, 0);
    // weighted burst {1,2,3,1}
    r(0, 0, 0, 4'b1111, wb, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b1111, wb, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b1111, wb, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0001, 0, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0000, 1, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0010, 0, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0010, 1, 1, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0000, 1, 1, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0100, 0, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0100, 1, 2, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0100, 1, 2, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0000, 1, 2, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b1000, 0, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0000, 1, 3, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0001, 0, 0, 1);
    r(1, 1, 0, 4'b1111, wb, 1, 4'b0000, 1, 0, 1);
    // masking: ch1 weight 0
    r(0, 0, 0, 4'b0111, wm, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0111, wm, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0111, wm, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0001, 0, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0000, 1, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0100, 0, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0000, 1, 2, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0001, 0, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0000, 1, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0100, 0, 0, 1);
    r(1, 1, 0, 4'b0111, wm, 1, 4'b0000, 1, 2, 1);
    // backpressure: ch0 weight 3, tx_rdy low 5 cycles
    r(0, 0, 0, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b0001, wp, 1, 4'b0001, 0, 0, 1);
    for (int i = 0; i < 5; i++) r(1, 1, 0, 4'b0001, wp, 0, 4'b0000, 1, 0, 1);
    r(1, 1, 0, 4'b0001, wp, 1, 4'b0001, 1, 0, 1);
    r(1, 1, 0, 4'b0001, wp, 1, 4'b0001, 1, 0, 1);
    r(1, 1, 0, 4'b0000, wp, 1, 4'b0000, 1, 0, 1);
    r(1, 1, 0, 4'b0000, wp, 1, 4'b0000, 0, 0, 0);
    // yield: ch3 weight 4 drops vld after 2 transfers
    r(0, 0, 0, 4'b1000, wy, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b1000, wy, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b1000, wy, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1000, wy, 1, 4'b1000, 0, 0, 1);
    r(1, 1, 0, 4'b1000, wy, 1, 4'b1000, 1, 3, 1);
    r(1, 1, 0, 4'b0110, wy, 1, 4'b1000, 1, 3, 1);
    r(1, 1, 0, 4'b1110, wy, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1110, wy, 1, 4'b0010, 0, 0, 1);
    r(1, 1, 0, 4'b0000, wy, 1, 4'b0000, 1, 1, 1);
    r(1, 1, 0, 4'b0000, wy, 1, 4'b0000, 0, 0, 0);
    // mid-operation reset with tx_vld=1 in GRANT
    r(0, 0, 0, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b0001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b0001, wp, 1, 4'b0001, 0, 0, 1);
    r(0, 1, 0, 4'b0001, wp, 1, 4'b0001, 1, 0, 1);
    r(1, 1, 1, 4'b1001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 1, 4'b1001, wp, 1, 4'b0000, 0, 0, 0);
    r(1, 1, 0, 4'b1001, wp, 1, 4'b0001, 0, 0, 1);
    r(1, 1, 0, 4'b0000, wp, 1, 4'b0001, 1, 0, 1);
    r(1, 1, 0, 4'b0000, wp, 1, 4'b0000, 0, 0, 0);
    foreach (tbl[n]) begin
      @(negedge clk);
      rst_n = tbl[n].rst;
      chn_tx_vld = tbl[n].vld;
      chn_arb_weight = tbl[n].w;
      tx_rdy = tbl[n].trdy;
      #1;
      if (tbl[n].chk) begin
        cmp($sformatf("row%0d chn_tx_rdy", n), 64'(chn_tx_rdy), 64'(tbl[n].rdy));
        cmp($sformatf("row%0d tx_vld", n), 64'(tx_vld), 64'(tbl[n].tv));
        cmp($sformatf("row%0d sched_busy", n), 64'(sched_busy), 64'(tbl[n].busy));
        if (tbl[n].tv) begin
          cmp($sformatf("row%0d tx_chn_id", n), 64'(tx_chn_id), 64'(tbl[n].id));
          cmp($sformatf("row%0d tx_src_addr", n), 64'(tx_src_addr), 64'(src_of(int'(tbl[n].id))));
          cmp($sformatf("row%0d tx_dst_addr", n), 64'(tx_dst_addr), 64'(dst_of(int'(tbl[n].id))));
          cmp($sformatf("row%0d tx_len", n), 64'(tx_len), 64'(len_of(int'(tbl[n].id))));
        end
        if (tbl[n].zp) begin
          cmp($sformatf("row%0d zero tx_chn_id", n), 64'(tx_chn_id), 64'd0);
          cmp($sformatf("row%0d zero payload", n), {tx_src_addr, tx_dst_addr} | 64'(tx_len), 64'd0);
        end
      end
    end
    // idle with ptr=1: a lone ch2 request is forwarded two edges after it is raised
    @(negedge clk);
    chn_tx_vld = 4'b0100;
    chn_arb_weight = w1;
    tx_rdy = 1'b1;
    cnt = 0;
    #1;
    while (!tx_vld && cnt < 10) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    cmp("lone req latency", 64'(cnt), 64'd2);
    cmp("lone req id", 64'(tx_chn_id), 64'd2);
    cmp("lone req src", 64'(tx_src_addr), 64'(src_of(2)));
    chn_tx_vld = '0;
    @(negedge clk);
    #1;
    cmp("lone req drain vld", 64'(tx_vld), 64'd0);
    cmp("lone req drain busy", 64'(sched_busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adma_as_chn_sched.md
ADMA_AS_CHN_SCHED -- requirements
Module: adma_as_chn_sched

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly these five.
- DMA_CHN_NUM, 4, number of DMA channels.
- DMA_CHN_ARB_W, 3, per-channel arbitration weight width.
- DMA_LENGTH_W, 16, transaction length width.
- SRC_ADDR_W / DST_ADDR_W, 32 / 32, address widths.
- DMA_CHN_NUM_W, $clog2(DMA_CHN_NUM), derived and not user-set.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly these, clock and reset first.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- chn_tx_src_addr  in  DMA_CHN_NUM*SRC_ADDR_W  per-channel source address; channel i occupies slice i.
- chn_tx_dst_addr  in  DMA_CHN_NUM*DST_ADDR_W  per-channel destination address.
- chn_tx_len  in  DMA_CHN_NUM*DMA_LENGTH_W  per-channel length.
- chn_tx_vld  in  DMA_CHN_NUM  per-channel request valid.
- chn_tx_rdy  out  DMA_CHN_NUM  per-channel accept.
- chn_arb_weight  in  DMA_CHN_NUM*DMA_CHN_ARB_W  per-channel weight; 0 = channel masked.
- tx_src_addr, tx_dst_addr, tx_len  out  SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W  forwarded transaction to the AXI transaction fetch stage.
- tx_chn_id  out  DMA_CHN_NUM_W  originating channel of the forwarded transaction.
- tx_vld  out  1  forwarded valid.
- tx_rdy  in  1  fetch-stage ready.
- sched_busy  out  1  high while state is GRANT or the output register is full.

Function
REQ-003 Handshakes SHALL be valid/ready; a transfer occurs on a cycle where both are high.
REQ-004 The FSM SHALL have two states, IDLE and GRANT, and SHALL hold a grant index (gnt), a credit counter (crd, DMA_CHN_ARB_W bits) and a rotating pointer (ptr, DMA_CHN_NUM_W bits).
REQ-005 Channel i SHALL be eligible when chn_tx_vld[i]=1 and its weight is non-zero.
REQ-006 In IDLE with at least one eligible channel, the block SHALL select the first eligible channel searching ptr, ptr+1, ... modulo DMA_CHN_NUM.
- Next cycle: gnt=that channel, crd=its weight, state=GRANT.
- Arbitration latency is 1 cycle.
REQ-007 In IDLE, all chn_tx_rdy bits SHALL be 0.
REQ-008 In GRANT, chn_tx_rdy SHALL be one-hot at gnt and equal to out_free, where out_free = ~tx_vld | tx_rdy; all other bits SHALL be 0.
REQ-009 On a channel transfer, the output register SHALL load that channel's addr/len, set tx_chn_id=gnt and set tx_vld=1 next cycle; crd SHALL decrement by 1.
REQ-010 On a transfer with crd=1, the FSM SHALL go to IDLE and set ptr=(gnt+1) mod DMA_CHN_NUM.
REQ-011 In GRANT, if chn_tx_vld[gnt]=0, the FSM SHALL go to IDLE with ptr=(gnt+1) mod DMA_CHN_NUM (yield), and no transfer SHALL occur.
REQ-012 The weight SHALL be sampled only at grant time; weight changes during GRANT SHALL take effect at the next arbitration.
REQ-013 The output register SHALL be one entry.
- tx_vld and tx_* SHALL hold stable until tx_rdy.
- A new load in the same cycle as tx_rdy SHALL give back-to-back output, sustaining 1 transaction/cycle within a grant.
REQ-014 Payload SHALL pass unmodified; no arithmetic is performed on addresses or lengths.
REQ-015 With no eligible channel, the FSM SHALL stay in IDLE and ptr SHALL be unchanged.
REQ-016 Selection SHALL wrap from channel DMA_CHN_NUM-1 to channel 0.

Reset
REQ-017 When rst_n=0 at a clock edge, the following SHALL hold after that edge, regardless of state or a pending tx_vld: state=IDLE, gnt=0, crd=0, ptr=0, tx_vld=0, tx_chn_id=0, tx_src_addr/tx_dst_addr/tx_len=0, chn_tx_rdy=0, sched_busy=0.
REQ-018 The first grant after reset release SHALL be no earlier than the second edge with rst_n=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- Single request: ch2 vld, weight=1, tx_rdy=1 -> chn_tx_rdy[2] high 1 cycle after vld; tx_vld with tx_chn_id=2 the next cycle; FSM back to IDLE; ptr=3.
- Weighted burst: all 4 channels vld continuously, weights {1,2,3,1}, tx_rdy=1 -> tx_chn_id sequence 0,1,1,2,2,2,3,0,... with a 1-cycle gap per grant.
- Masking: ch1 weight=0, ch0/ch1/ch2 vld -> ch1 is never granted; order is 0,2,0,2.
- Backpressure: tx_rdy=0 for 5 cycles during a ch0 weight=3 grant -> tx_* stable; exactly one chn_tx_rdy pulse before the stall; none during it; 3 transfers total.
- Yield: ch3 granted with weight=4, ch3 drops vld after 2 transfers -> IDLE next cycle; ptr=0; the next grant goes to the first eligible channel from 0.
- Mid-operation reset: rst_n low for 1 cycle while tx_vld=1 and in GRANT -> all outputs 0 after the edge; ptr=0; a subsequent request is served normally.
